// File: rtl/tcam2_rule_loader_pkg.sv
// Shared types for the TCAM2 rule loader: command opcodes and FSM states.
package tcam2_rule_loader_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_DELETE = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/tcam2_rule_loader.sv
// TCAM2 write-port front-end: sequences write/delete/clear-all commands onto
// the TCAM2 write handshake and tracks which entries hold live rules.
module tcam2_rule_loader
    import tcam2_rule_loader_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH = 16,
    parameter int unsigned             ITEMS      = 16,
    parameter logic [DATA_WIDTH-1:0]   CLEAR_DATA = '0,
    parameter logic [DATA_WIDTH-1:0]   CLEAR_MASK = '0,
    localparam int unsigned            AW = (ITEMS > 1) ? $clog2(ITEMS) : 1,
    localparam int unsigned            CW = $clog2(ITEMS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cmd_op,
    input  logic [AW-1:0]         cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [DATA_WIDTH-1:0] cmd_mask,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    output logic                  cmd_err,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] wr_mask,
    output logic [AW-1:0]         wr_addr,
    output logic                  wr_en,
    input  logic                  wr_rdy,
    output logic                  busy,
    output logic [ITEMS-1:0]      entry_vld,
    output logic [CW-1:0]         vld_cnt
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(ITEMS - 1);

    state_e                  state, state_nxt;
    logic                    set_pend, set_pend_nxt;
    logic                    cmd_rdy_nxt, cmd_err_nxt, wr_en_nxt, busy_nxt;
    logic [DATA_WIDTH-1:0]   wr_data_nxt, wr_mask_nxt;
    logic [AW-1:0]           wr_addr_nxt;
    logic [ITEMS-1:0]        entry_vld_nxt;
    logic [CW-1:0]           vld_cnt_nxt;
    logic                    accept, addr_ok, handshake;

    assign accept    = cmd_vld & cmd_rdy;
    assign addr_ok   = 32'(cmd_addr) < ITEMS;
    assign handshake = wr_en & wr_rdy;

    // Register all state and outputs; synchronous active-low reset abandons any write in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            set_pend  <= 1'b0;
            cmd_rdy   <= 1'b1;
            cmd_err   <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            wr_mask   <= '0;
            wr_addr   <= '0;
            busy      <= 1'b0;
            entry_vld <= '0;
            vld_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            set_pend  <= set_pend_nxt;
            cmd_rdy   <= cmd_rdy_nxt;
            cmd_err   <= cmd_err_nxt;
            wr_en     <= wr_en_nxt;
            wr_data   <= wr_data_nxt;
            wr_mask   <= wr_mask_nxt;
            wr_addr   <= wr_addr_nxt;
            busy      <= busy_nxt;
            entry_vld <= entry_vld_nxt;
            vld_cnt   <= vld_cnt_nxt;
        end
    end

    // Next-state and output decode; invalidation happens at acceptance, validation only after the write lands.
    always_comb begin
        state_nxt     = state;
        set_pend_nxt  = set_pend;
        cmd_err_nxt   = 1'b0;
        wr_en_nxt     = wr_en;
        wr_data_nxt   = wr_data;
        wr_mask_nxt   = wr_mask;
        wr_addr_nxt   = wr_addr;
        entry_vld_nxt = entry_vld;
        vld_cnt_nxt   = vld_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    case (op_e'(cmd_op))
                        OP_WRITE: begin
                            if (addr_ok) begin
                                state_nxt    = WRITE;
                                set_pend_nxt = 1'b1;
                                wr_en_nxt    = 1'b1;
                                wr_addr_nxt  = cmd_addr;
                                wr_data_nxt  = cmd_data;
                                wr_mask_nxt  = cmd_mask;
                            end else begin
                                cmd_err_nxt  = 1'b1;
                            end
                        end
                        OP_DELETE: begin
                            if (addr_ok) begin
                                state_nxt    = WRITE;
                                set_pend_nxt = 1'b0;
                                wr_en_nxt    = 1'b1;
                                wr_addr_nxt  = cmd_addr;
                                wr_data_nxt  = CLEAR_DATA;
                                wr_mask_nxt  = CLEAR_MASK;
                                if (entry_vld[cmd_addr]) begin
                                    entry_vld_nxt[cmd_addr] = 1'b0;
                                    vld_cnt_nxt             = vld_cnt - CW'(1);
                                end
                            end else begin
                                cmd_err_nxt  = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            state_nxt     = CLEAR;
                            set_pend_nxt  = 1'b0;
                            wr_en_nxt     = 1'b1;
                            wr_addr_nxt   = '0;
                            wr_data_nxt   = CLEAR_DATA;
                            wr_mask_nxt   = CLEAR_MASK;
                            entry_vld_nxt = '0;
                            vld_cnt_nxt   = '0;
                        end
                        default: cmd_err_nxt = 1'b1;
                    endcase
                end
            end
            WRITE: begin
                if (handshake) begin
                    state_nxt = IDLE;
                    wr_en_nxt = 1'b0;
                    if (set_pend && !entry_vld[wr_addr]) begin
                        entry_vld_nxt[wr_addr] = 1'b1;
                        vld_cnt_nxt            = vld_cnt + CW'(1);
                    end
                end
            end
            CLEAR: begin
                if (handshake) begin
                    if (wr_addr == LAST_ADDR) begin
                        state_nxt = IDLE;
                        wr_en_nxt = 1'b0;
                    end else begin
                        wr_addr_nxt = wr_addr + AW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                wr_en_nxt = 1'b0;
            end
        endcase

        cmd_rdy_nxt = (state_nxt == IDLE);
        busy_nxt    = (state_nxt != IDLE);
    end

endmodule
